// File: rtl/aes_sched_pkg.sv
// Package for the AES-128 core scheduler.
// Provides the block and timeout-counter widths and the scheduler state enum.
package aes_sched_pkg;

    localparam int AES_BLK_W    = 128;
    localparam int AES_TO_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } aes_sched_state_e;

endpackage

// File: rtl/aes_scheduler_if.sv
// Requester-side bus of the AES scheduler.
//   req_valid/req_ready          : per-requester request handshake
//   req_plaintext/req_key        : flattened operands, requester i at [i*128 +: 128]
//   rsp_valid/rsp_ready          : per-requester response handshake
//   rsp_data/rsp_err             : shared ciphertext and timeout flag
// master = requesters, slave = scheduler.
interface aes_scheduler_if
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*AES_BLK_W-1:0] req_plaintext;
    logic [NUM_REQ*AES_BLK_W-1:0] req_key;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [AES_BLK_W-1:0]         rsp_data;
    logic                         rsp_err;

    modport master (
        output req_valid, req_plaintext, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_plaintext, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/aes_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   last_i  : index of the most recent winner; search starts at last_i+1
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : binary index of the grant
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan requesters from last_i+1 around to last_i, keep the first hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/aes_scheduler.sv
// Shares one iterative AES-128 core between NUM_REQ requesters.
// Round-robin arbitration, then CLEAR (core reset pulse), LAUNCH (start
// pulse), WAIT (sticky core_done) and RESP (result to the issuing requester).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : requester request/response bus
//   core_rst/core_start : core control, core_rst = reset | CLEAR
//   core_plaintext/key  : operands, stable from CLEAR through RESP
//   core_ciphertext     : core result
//   core_done           : sticky done, only looked at in WAIT
// Optional feature: define AES_SCHED_TIMEOUT_EN to abort a job that has
// spent TIMEOUT cycles in WAIT (rsp_err=1, rsp_data=0). Without it WAIT is
// unbounded and rsp_err is tied to 0.
module aes_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_scheduler_if.slave       bus,
    output logic                 core_rst,
    output logic                 core_start,
    output logic [AES_BLK_W-1:0] core_plaintext,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0] core_ciphertext,
    input  logic                 core_done
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    aes_sched_state_e     state_q, state_d;
    logic [IDX_W-1:0]     idx_q, last_q, grant_idx_s;
    logic [NUM_REQ-1:0]   grant_s, rsp_valid_q;
    logic [AES_BLK_W-1:0] pt_q, key_q, rsp_data_q;
    logic                 start_q, accept_s, done_hit_s, to_hit_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant_s),
        .idx_o   (grant_idx_s)
    );

`ifdef AES_SCHED_TIMEOUT_EN
    logic [AES_TO_CNT_W-1:0] to_cnt_q;
    logic                    rsp_err_q;

    // WAIT-cycle counter: zero in the first WAIT cycle, +1 every WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_LAUNCH) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_q <= to_cnt_q + AES_TO_CNT_W'(1);
        end
    end

    // Count is about to reach TIMEOUT in this cycle; a done in the same cycle wins
    assign to_hit_s = (state_q == ST_WAIT) && !core_done &&
                      (to_cnt_q == AES_TO_CNT_W'(TIMEOUT - 1));

    // Error flag: set by an abort, cleared by a normal completion
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if (done_hit_s) begin
            rsp_err_q <= 1'b0;
        end else if (to_hit_s) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign to_hit_s    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state logic of the job sequencer
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        done_hit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant_s) begin
                    accept_s = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR:  state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    done_hit_s = 1'b1;
                    state_d    = ST_RESP;
                end else if (to_hit_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready[idx_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand, result and registered-output updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            pt_q        <= '0;
            key_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= (state_d == ST_LAUNCH);
            rsp_valid_q <= (state_d == ST_RESP) ? (ONE_HOT0 << idx_q) : '0;
            if (accept_s) begin
                pt_q   <= bus.req_plaintext[int'(grant_idx_s)*AES_BLK_W +: AES_BLK_W];
                key_q  <= bus.req_key[int'(grant_idx_s)*AES_BLK_W +: AES_BLK_W];
                idx_q  <= grant_idx_s;
                last_q <= grant_idx_s;
            end
            if (done_hit_s) begin
                rsp_data_q <= core_ciphertext;
            end else if (to_hit_s) begin
                rsp_data_q <= '0;
            end
        end
    end

    // Acceptance strobe is combinational and suppressed while in reset
    always_comb begin
        if ((state_q == ST_IDLE) && !reset) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // The core is held in reset for the whole of reset as well as during CLEAR
    assign core_rst       = reset | (state_q == ST_CLEAR);
    assign core_start     = start_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_aes_scheduler.sv
// Directed testbench for aes_scheduler with a stub AES core whose done
// appears 13 cycles after start (done seen at A+15). The stub returns the
// FIPS-197 ciphertext for the FIPS vector and pt^key otherwise.
module tb_aes_scheduler;
    import aes_sched_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 31;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'hffff0000ffff0000ffff0000ffff0000;
    localparam logic [127:0] KEY_B = 128'h0000ffff0000ffff0000ffff0000ffff;
    localparam logic [127:0] CT_B  = 128'hffffffffffffffffffffffffffffffff;

    logic         clk;
    logic         reset;
    logic         core_rst, core_start, core_done;
    logic [127:0] core_plaintext, core_key, core_ciphertext;

    logic         stub_busy, stub_done, force_done, core_hang;
    logic [3:0]   stub_cnt;
    logic [127:0] stub_ct;

    int n_checks = 0;
    int n_fail   = 0;

    aes_scheduler_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    aes_scheduler #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if),
        .core_rst        (core_rst),
        .core_start      (core_start),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_ciphertext (core_ciphertext),
        .core_done       (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] stub_cipher(input logic [127:0] pt, input logic [127:0] key);
        if (pt == PT_A && key == KEY_A) return CT_A;
        else return pt ^ key;
    endfunction

    // Stub core: sticky done 13 cycles after start unless hung
    always @(posedge clk) begin
        if (core_rst) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 4'd0;
            stub_done <= 1'b0;
            stub_ct   <= 128'd0;
        end else if (core_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 4'd0;
        end else if (stub_busy) begin
            if (stub_cnt == 4'd11 && !core_hang) begin
                stub_done <= 1'b1;
                stub_busy <= 1'b0;
                stub_ct   <= stub_cipher(core_plaintext, core_key);
            end else begin
                stub_cnt <= stub_cnt + 4'd1;
            end
        end
    end

    assign core_done       = stub_done | force_done;
    assign core_ciphertext = stub_ct;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in acceptance cycle A; returns cycles until rsp_valid, -1 on expiry
    task automatic wait_rsp(input logic [1:0] keep, output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) bus_if.req_valid = bus_if.req_valid & keep;
            if (bus_if.rsp_valid != '0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int lat;
        int ngr, nrsp, bad;
        logic [1:0]   gr [3];
        int           gt [3];
        logic [1:0]   rv [4];
        logic [127:0] rd [4];

        reset = 1'b1;
        force_done = 1'b0;
        core_hang  = 1'b0;
        bus_if.req_valid     = 2'b00;
        bus_if.rsp_ready     = 2'b00;
        bus_if.req_plaintext = {PT_B, PT_A};
        bus_if.req_key       = {KEY_B, KEY_A};
        repeat (3) tick();

        // Reset values
        bus_if.req_valid = 2'b01;
        #1;
        check_eq("rst_req_ready", 128'(bus_if.req_ready), 128'd0);
        check_eq("rst_rsp_valid", 128'(bus_if.rsp_valid), 128'd0);
        check_eq("rst_rsp_data", bus_if.rsp_data, 128'd0);
        check_eq("rst_rsp_err", 128'(bus_if.rsp_err), 128'd0);
        check_eq("rst_core_rst", 128'(core_rst), 128'd1);
        check_eq("rst_core_start", 128'(core_start), 128'd0);
        check_eq("rst_core_pt", core_plaintext, 128'd0);
        check_eq("rst_core_key", core_key, 128'd0);

        // Single request from req0
        reset = 1'b0;
        #1;
        check_eq("single_ready", 128'(bus_if.req_ready), 128'd1);
        tick();
        bus_if.req_valid = 2'b00;
        check_eq("clear_core_rst", 128'(core_rst), 128'd1);
        check_eq("clear_core_pt", core_plaintext, PT_A);
        check_eq("clear_core_key", core_key, KEY_A);
        tick();
        check_eq("launch_start", 128'(core_start), 128'd1);
        check_eq("launch_core_rst", 128'(core_rst), 128'd0);
        tick();
        check_eq("wait_start", 128'(core_start), 128'd0);
        lat = 0;
        for (int c = 4; c <= 60; c++) begin
            tick();
            if (bus_if.rsp_valid != '0) begin
                lat = c;
                break;
            end
        end
        check_eq("single_latency", 128'(lat), 128'd16);
        check_eq("single_rsp_valid", 128'(bus_if.rsp_valid), 128'd1);
        check_eq("single_rsp_data", bus_if.rsp_data, CT_A);
        check_eq("single_rsp_err", 128'(bus_if.rsp_err), 128'd0);
        check_eq("resp_core_pt", core_plaintext, PT_A);
        bus_if.rsp_ready = 2'b01;
        tick();
        bus_if.rsp_ready = 2'b00;
        check_eq("single_rsp_drop", 128'(bus_if.rsp_valid), 128'd0);

        // Contention with rsp_ready held high
        do_reset();
        bus_if.req_valid = 2'b11;
        bus_if.rsp_ready = 2'b11;
        ngr = 0;
        nrsp = 0;
        for (int c = 0; c < 60; c++) begin
            if (ngr >= 3) bus_if.req_valid = 2'b00;
            #1;
            if (bus_if.req_ready != '0 && ngr < 3) begin
                gr[ngr] = bus_if.req_ready;
                gt[ngr] = c;
                ngr++;
            end
            if (bus_if.rsp_valid != '0 && nrsp < 4) begin
                rv[nrsp] = bus_if.rsp_valid;
                rd[nrsp] = bus_if.rsp_data;
                nrsp++;
            end
            tick();
        end
        bus_if.rsp_ready = 2'b00;
        check_eq("cont_num_grants", 128'(ngr), 128'd3);
        check_eq("cont_num_rsp", 128'(nrsp), 128'd3);
        if (ngr == 3 && nrsp == 3) begin
            check_eq("cont_grant0", 128'(gr[0]), 128'd1);
            check_eq("cont_grant1", 128'(gr[1]), 128'd2);
            check_eq("cont_grant2", 128'(gr[2]), 128'd1);
            check_eq("cont_ii_01", 128'(gt[1] - gt[0]), 128'd17);
            check_eq("cont_ii_12", 128'(gt[2] - gt[1]), 128'd17);
            check_eq("cont_rv0", 128'(rv[0]), 128'd1);
            check_eq("cont_rv1", 128'(rv[1]), 128'd2);
            check_eq("cont_rv2", 128'(rv[2]), 128'd1);
            check_eq("cont_rd0", rd[0], CT_A);
            check_eq("cont_rd1", rd[1], CT_B);
            check_eq("cont_rd2", rd[2], CT_A);
        end

        // Response stall: req1 holds off while req0 waits (req0's ready is ignored)
        bus_if.req_valid = 2'b11;
        bus_if.rsp_ready = 2'b01;
        #1;
        check_eq("stall_grant1", 128'(bus_if.req_ready), 128'd2);
        wait_rsp(2'b01, lat);
        check_eq("stall_latency", 128'(lat), 128'd16);
        for (int c = 0; c < 5; c++) begin
            check_eq("stall_rsp_valid", 128'(bus_if.rsp_valid), 128'd2);
            check_eq("stall_rsp_data", bus_if.rsp_data, CT_B);
            check_eq("stall_req_ready", 128'(bus_if.req_ready), 128'd0);
            tick();
        end
        bus_if.rsp_ready = 2'b10;
        tick();
        bus_if.rsp_ready = 2'b00;
        #1;
        check_eq("stall_release_valid", 128'(bus_if.rsp_valid), 128'd0);
        check_eq("stall_req0_ready", 128'(bus_if.req_ready), 128'd1);
        wait_rsp(2'b00, lat);
        check_eq("stall_req0_lat", 128'(lat), 128'd16);
        check_eq("stall_req0_valid", 128'(bus_if.rsp_valid), 128'd1);
        check_eq("stall_req0_data", bus_if.rsp_data, CT_A);
        bus_if.rsp_ready = 2'b01;
        tick();
        bus_if.rsp_ready = 2'b00;

        // Reset at A+8 of a req1 job
        bus_if.req_valid = 2'b10;
        #1;
        check_eq("mid_grant", 128'(bus_if.req_ready), 128'd2);
        tick();
        bus_if.req_valid = 2'b00;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check_eq("mid_core_rst_now", 128'(core_rst), 128'd1);
        tick();
        check_eq("mid_rsp_valid", 128'(bus_if.rsp_valid), 128'd0);
        check_eq("mid_core_start", 128'(core_start), 128'd0);
        check_eq("mid_core_pt", core_plaintext, 128'd0);
        check_eq("mid_core_key", core_key, 128'd0);
        check_eq("mid_rsp_data", bus_if.rsp_data, 128'd0);
        tick();
        check_eq("mid_core_rst_hold", 128'(core_rst), 128'd1);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_if.rsp_valid != '0) bad++;
        end
        check_eq("mid_no_stale_rsp", 128'(bad), 128'd0);
        bus_if.req_valid = 2'b10;
        #1;
        check_eq("post_rst_grant", 128'(bus_if.req_ready), 128'd2);
        wait_rsp(2'b00, lat);
        check_eq("post_rst_lat", 128'(lat), 128'd16);
        check_eq("post_rst_valid", 128'(bus_if.rsp_valid), 128'd2);
        check_eq("post_rst_data", bus_if.rsp_data, CT_B);
        bus_if.rsp_ready = 2'b10;
        tick();
        bus_if.rsp_ready = 2'b00;

        // core_done forced high while idle must not produce a response
        force_done = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_if.rsp_valid != '0 || core_start) bad++;
        end
        force_done = 1'b0;
        check_eq("idle_done_ignored", 128'(bad), 128'd0);

`ifdef AES_SCHED_TIMEOUT_EN
        // Hung core: abort TIMEOUT cycles after entering WAIT (A+3)
        core_hang = 1'b1;
        bus_if.req_valid = 2'b01;
        #1;
        wait_rsp(2'b00, lat);
        check_eq("to_latency", 128'(lat), 128'(3 + TIMEOUT));
        check_eq("to_rsp_valid", 128'(bus_if.rsp_valid), 128'd1);
        check_eq("to_rsp_err", 128'(bus_if.rsp_err), 128'd1);
        check_eq("to_rsp_data", bus_if.rsp_data, 128'd0);
        bus_if.rsp_ready = 2'b01;
        tick();
        bus_if.rsp_ready = 2'b00;
        core_hang = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/aes_scheduler.md
# aes_scheduler

Shares one iterative AES-128 encryption core between `NUM_REQ` requesters. It arbitrates round-robin, registers the winner's plaintext and key, and restarts the core with a clear pulse. It then launches the job, waits for the core's sticky `done`, and returns the ciphertext to the requester that issued it. It sits between the system-side request ports and the core's `start/plaintext/key/ciphertext/done` pins.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 31: maximum cycles spent in WAIT before a job is aborted (used only with the timeout feature).
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle, one-hot or zero.
- `req_plaintext` in NUM_REQ*128: flattened; requester i uses bits [i*128 +: 128].
- `req_key` in NUM_REQ*128: flattened, same packing as `req_plaintext`.
- `rsp_valid` out NUM_REQ: result available, one-hot or zero.
- `rsp_ready` in NUM_REQ: requester takes the result.
- `rsp_data` out 128: ciphertext, shared by all requesters.
- `rsp_err` out 1: job aborted by timeout.
- `core_rst` out 1: reset to the core, active-high.
- `core_start` out 1: start pulse to the core.
- `core_plaintext` out 128: plaintext operand to the core.
- `core_key` out 128: key operand to the core.
- `core_ciphertext` in 128: result from the core.
- `core_done` in 1: sticky done from the core; it clears only on `core_rst`.

## Operation
- States: IDLE, CLEAR, LAUNCH, WAIT, RESP.
- **IDLE**
  - Grant goes to the first set `req_valid` bit, searching from `last+1` modulo NUM_REQ.
  - `req_ready[grant]` is 1 combinationally, and is 0 while `reset` is high.
  - On `req_valid & req_ready`: latch the operands into `core_plaintext` and `core_key`, store the grant index, set `last` to the grant, then go to CLEAR.
  - If no `req_valid` bit is set, stay in IDLE. Arbitration is recomputed every IDLE cycle, so a valid that drops before acceptance is never granted.
- **CLEAR**: `core_rst` is 1 for exactly one cycle, then go to LAUNCH.
- **LAUNCH**: `core_start` is 1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On `core_done` = 1: capture `core_ciphertext` into `rsp_data`, set `rsp_err` to 0, go to RESP.
  - The timeout rule is in Configuration.
- **RESP**
  - `rsp_valid[idx]` is 1.
  - On `rsp_ready[idx]`: go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `core_plaintext` and `core_key` hold stable from CLEAR through RESP.
- `core_done` is ignored outside WAIT.
- `core_rst` = `reset` OR (state == CLEAR).
- Reset values:
  - state IDLE;
  - `last` = NUM_REQ-1, so requester 0 has first priority;
  - `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0;
  - `core_start` 0, `core_plaintext` 0, `core_key` 0;
  - `core_rst` 1.
- Reset mid-job: the job is dropped with no response, and the core is held in reset for as long as `reset` is high.

## Timing
- Acceptance happens in cycle A.
- CLEAR is A+1 and LAUNCH is A+2.
- With the nominal core, `core_done` is seen at A+15 and `rsp_valid` rises at A+16.
- Latency is data-independent.
- `rsp_ready` can be high in the first RESP cycle; the scheduler is then in IDLE the next cycle.
- Back-to-back jobs have at least one IDLE cycle between them, giving a minimum initiation interval of 17 cycles.
- A requester whose result is stalled in RESP blocks all other requesters. This is intended: there is no result buffering.

## Configuration
- Macro: `AES_SCHED_TIMEOUT_EN`.
- **With the macro defined**
  - A 6-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If the count reaches `TIMEOUT` with no `core_done`, go to RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - `done` arriving in the same cycle the count reaches `TIMEOUT` wins: the result is normal, with `rsp_err` = 0.
- **Without the macro**
  - WAIT lasts indefinitely.
  - `rsp_err` is tied to 0 and no counter exists.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum;
  - `AES_BLK_W` = 128;
  - `AES_TO_CNT_W` = 6.
- Sub-module `rr_arbiter`, parameterized by `NUM_REQ`:
  - inputs: request vector, `last` pointer;
  - outputs: one-hot grant and binary index;
  - purely combinational.
- The scheduler instantiates `rr_arbiter`. The core itself is instantiated by the parent, not inside the scheduler.

## Test plan
- **Single request.** After reset, req0 sends plaintext 0x00112233445566778899aabbccddeeff with key 0x000102030405060708090a0b0c0d0e0f.
  - `rsp_valid[0]` rises 16 cycles after acceptance.
  - `rsp_data` = 0x69c4e0d86a7b0430d8cdb78070b4c55a and `rsp_err` = 0.
- **Contention.** req0 and req1 are valid in the same cycle, with `rsp_ready` held high.
  - Grant order is 0, then 1, then 0.
  - Each requester receives its own ciphertext, and the jobs start 17 cycles apart.
- **Response stall.** req1 holds `rsp_ready` low for 5 cycles.
  - `rsp_data` and `rsp_valid[1]` stay stable throughout.
  - `req_ready` stays 0 for req0 until req1's handshake.
- **Reset mid-job.** `reset` is asserted at A+8.
  - `core_rst` is 1 and all outputs return to their reset values.
  - The next req1 job completes with correct data.
- **Timeout (`AES_SCHED_TIMEOUT_EN`).** A stub core never raises `core_done`.
  - `rsp_err` = 1 and `rsp_data` = 0 exactly `TIMEOUT` cycles after entering WAIT.
- **Done only in WAIT.** `core_done` is forced high during IDLE.
  - No response is generated.
